// File: rtl/minmax_tag_queue.sv
// rtl/minmax_tag_queue.sv - double-ended priority queue of {tag, data} entries
// Dequeue removes the smallest- or largest-tag entry; min/max are rebuilt by a DEPTH-cycle rescan.
module minmax_tag_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       enq_in,
  input  logic [DATA_WIDTH-1:0]      enq_data_in,
  input  logic [TAG_WIDTH-1:0]       enq_tag_in,
  input  logic                       deq_min_in,
  input  logic                       deq_max_in,
  output logic                       deq_ready_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [TAG_WIDTH-1:0]       tag_out,
  output logic                       valid_out,
  output logic [TAG_WIDTH-1:0]       min_tag_out,
  output logic [TAG_WIDTH-1:0]       max_tag_out,
  output logic [$clog2(DEPTH):0]     size_out,
  output logic                       empty_out,
  output logic                       full_out
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [SW-1:0]         size_q, size_d;
  logic [TAG_WIDTH-1:0]  min_tag_q, min_tag_d, max_tag_q, max_tag_d;
  logic [IW-1:0]         min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic [TAG_WIDTH-1:0]  scan_min_q, scan_min_d, scan_max_q, scan_max_d;
  logic [IW-1:0]         scan_min_idx_q, scan_min_idx_d, scan_max_idx_q, scan_max_idx_d;
  logic                  scan_have_q, scan_have_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;

  logic                  enq_acc, deq_acc;
  logic [IW-1:0]         free_idx, deq_idx;
  logic [TAG_WIDTH-1:0]  c_min_t, c_max_t;
  logic [IW-1:0]         c_min_i, c_max_i;
  logic                  c_have;

  // Ordering key is (tag, slot index): equal tags resolve to the lower slot for both extremes.
  function automatic logic min_wins(input logic [TAG_WIDTH-1:0] t, input logic [IW-1:0] i,
                                    input logic [TAG_WIDTH-1:0] ct, input logic [IW-1:0] ci,
                                    input logic cv);
    return !cv || (t < ct) || ((t == ct) && (i < ci));
  endfunction

  function automatic logic max_wins(input logic [TAG_WIDTH-1:0] t, input logic [IW-1:0] i,
                                    input logic [TAG_WIDTH-1:0] ct, input logic [IW-1:0] ci,
                                    input logic cv);
    return !cv || (t > ct) || ((t == ct) && (i < ci));
  endfunction

  assign empty_out     = (size_q == '0);
  assign full_out      = (size_q == SW'(DEPTH));
  assign deq_ready_out = (state_q == IDLE) && !empty_out;
  assign size_out      = size_q;
  assign min_tag_out   = min_tag_q;
  assign max_tag_out   = max_tag_q;
  assign valid_out     = valid_out_q;
  assign data_out      = data_out_q;
  assign tag_out       = tag_out_q;

  assign enq_acc = enq_in && !full_out;
  assign deq_acc = (deq_min_in || deq_max_in) && deq_ready_out;
  assign deq_idx = deq_min_in ? min_idx_q : max_idx_q;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    data_d         = data_q;
    min_tag_d      = min_tag_q;
    max_tag_d      = max_tag_q;
    min_idx_d      = min_idx_q;
    max_idx_d      = max_idx_q;
    scan_min_d     = scan_min_q;
    scan_max_d     = scan_max_q;
    scan_min_idx_d = scan_min_idx_q;
    scan_max_idx_d = scan_max_idx_q;
    scan_have_d    = scan_have_q;
    scan_idx_d     = scan_idx_q;
    valid_out_d    = 1'b0;
    data_out_d     = data_out_q;
    tag_out_d      = tag_out_q;
    c_min_t        = scan_min_q;
    c_max_t        = scan_max_q;
    c_min_i        = scan_min_idx_q;
    c_max_i        = scan_max_idx_q;
    c_have         = scan_have_q;

    // The freed slot stays valid in valid_q this cycle, so an enq never lands in it.
    if (deq_acc) begin
      valid_d[deq_idx] = 1'b0;
      valid_out_d      = 1'b1;
      data_out_d       = data_q[deq_idx];
      tag_out_d        = tag_q[deq_idx];
    end
    if (enq_acc) begin
      valid_d[free_idx] = 1'b1;
      tag_d[free_idx]   = enq_tag_in;
      data_d[free_idx]  = enq_data_in;
    end
    size_d = size_q + SW'(enq_acc) - SW'(deq_acc);

    case (state_q)
      IDLE: begin
        if (deq_acc) begin
          if (size_d == '0) begin
            min_tag_d = '1;
            max_tag_d = '0;
          end else begin
            state_d     = SCAN;
            scan_idx_d  = '0;
            scan_have_d = 1'b0;
          end
        end else if (enq_acc) begin
          if (min_wins(enq_tag_in, free_idx, min_tag_q, min_idx_q, !empty_out)) begin
            min_tag_d = enq_tag_in;
            min_idx_d = free_idx;
          end
          if (max_wins(enq_tag_in, free_idx, max_tag_q, max_idx_q, !empty_out)) begin
            max_tag_d = enq_tag_in;
            max_idx_d = free_idx;
          end
        end
      end
      SCAN: begin
        if (valid_q[scan_idx_q]) begin
          if (min_wins(tag_q[scan_idx_q], scan_idx_q, c_min_t, c_min_i, c_have)) begin
            c_min_t = tag_q[scan_idx_q];
            c_min_i = scan_idx_q;
          end
          if (max_wins(tag_q[scan_idx_q], scan_idx_q, c_max_t, c_max_i, c_have)) begin
            c_max_t = tag_q[scan_idx_q];
            c_max_i = scan_idx_q;
          end
          c_have = 1'b1;
        end
        // A mid-scan enq joins the running candidates; a later visit of its slot is a no-op.
        if (enq_acc) begin
          if (min_wins(enq_tag_in, free_idx, c_min_t, c_min_i, c_have)) begin
            c_min_t = enq_tag_in;
            c_min_i = free_idx;
          end
          if (max_wins(enq_tag_in, free_idx, c_max_t, c_max_i, c_have)) begin
            c_max_t = enq_tag_in;
            c_max_i = free_idx;
          end
          c_have = 1'b1;
        end
        scan_min_d     = c_min_t;
        scan_max_d     = c_max_t;
        scan_min_idx_d = c_min_i;
        scan_max_idx_d = c_max_i;
        scan_have_d    = c_have;
        if (scan_idx_q == IW'(DEPTH - 1)) begin
          state_d   = IDLE;
          min_tag_d = c_min_t;
          max_tag_d = c_max_t;
          min_idx_d = c_min_i;
          max_idx_d = c_max_i;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    tag_q          <= tag_d;
    data_q         <= data_d;
    min_idx_q      <= min_idx_d;
    max_idx_q      <= max_idx_d;
    scan_min_q     <= scan_min_d;
    scan_max_q     <= scan_max_d;
    scan_min_idx_q <= scan_min_idx_d;
    scan_max_idx_q <= scan_max_idx_d;
    scan_have_q    <= scan_have_d;
    scan_idx_q     <= scan_idx_d;
    if (rst_in) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      size_q      <= '0;
      min_tag_q   <= '1;
      max_tag_q   <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      size_q      <= size_d;
      min_tag_q   <= min_tag_d;
      max_tag_q   <= max_tag_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      tag_out_q   <= tag_out_d;
    end
  end
endmodule

// File: tb/tb_minmax_tag_queue.sv
// tb/tb_minmax_tag_queue.sv - directed and randomized bench for minmax_tag_queue
// Reference model keeps slots as plain arrays and picks extremes by linear search.
module tb_minmax_tag_queue;
  localparam int DW = 32;
  localparam int TW = 32;
  localparam int DEPTH = 8;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          enq_in = 1'b0;
  logic [DW-1:0] enq_data_in = '0;
  logic [TW-1:0] enq_tag_in = '0;
  logic          deq_min_in = 1'b0;
  logic          deq_max_in = 1'b0;
  logic          deq_ready_out;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          valid_out;
  logic [TW-1:0] min_tag_out;
  logic [TW-1:0] max_tag_out;
  logic [3:0]    size_out;
  logic          empty_out;
  logic          full_out;

  int total = 0;
  int bad = 0;

  bit            mv [DEPTH];
  logic [TW-1:0] mt [DEPTH];
  logic [DW-1:0] md [DEPTH];
  int            busy = 0;
  logic          evout = 1'b0;
  logic [TW-1:0] etag = '0;
  logic [DW-1:0] edata = '0;

  minmax_tag_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enq_in(enq_in), .enq_data_in(enq_data_in),
    .enq_tag_in(enq_tag_in), .deq_min_in(deq_min_in), .deq_max_in(deq_max_in),
    .deq_ready_out(deq_ready_out), .data_out(data_out), .tag_out(tag_out),
    .valid_out(valid_out), .min_tag_out(min_tag_out), .max_tag_out(max_tag_out),
    .size_out(size_out), .empty_out(empty_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mv[i]) n++;
    return n;
  endfunction

  function automatic int amin();
    int b = -1;
    for (int i = 0; i < DEPTH; i++)
      if (mv[i] && (b < 0 || mt[i] < mt[b])) b = i;
    return b;
  endfunction

  function automatic int amax();
    int b = -1;
    for (int i = 0; i < DEPTH; i++)
      if (mv[i] && (b < 0 || mt[i] > mt[b])) b = i;
    return b;
  endfunction

  task automatic model(input logic e, input logic [TW-1:0] t, input logic [DW-1:0] d,
                       input logic mn, input logic mx, input logic r);
    int sz, fr, idx;
    bit rdy, eok, dok;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
      busy = 0; evout = 1'b0; etag = '0; edata = '0;
      return;
    end
    sz  = mcount();
    rdy = (busy == 0) && (sz > 0);
    eok = e && (sz < DEPTH);
    dok = (mn || mx) && rdy;
    fr = -1;
    for (int i = 0; i < DEPTH; i++) if (!mv[i] && fr < 0) fr = i;
    evout = dok;
    if (dok) begin
      idx = mn ? amin() : amax();
      etag = mt[idx]; edata = md[idx]; mv[idx] = 1'b0;
    end
    if (eok) begin
      mv[fr] = 1'b1; mt[fr] = t; md[fr] = d;
    end
    if (dok) busy = (mcount() > 0) ? DEPTH : 0;
    else if (busy > 0) busy--;
  endtask

  task automatic compare_all();
    int sz, a;
    sz = mcount();
    check("size", 64'(size_out), 64'(sz));
    check("empty", 64'(empty_out), 64'(sz == 0));
    check("full", 64'(full_out), 64'(sz == DEPTH));
    check("ready", 64'(deq_ready_out), 64'(busy == 0 && sz > 0));
    check("valid_out", 64'(valid_out), 64'(evout));
    check("tag_out", 64'(tag_out), 64'(etag));
    check("data_out", 64'(data_out), 64'(edata));
    if (busy == 0) begin
      a = amin();
      check("min_tag", 64'(min_tag_out), (a < 0) ? 64'hFFFF_FFFF : 64'(mt[a]));
      a = amax();
      check("max_tag", 64'(max_tag_out), (a < 0) ? 64'h0 : 64'(mt[a]));
    end
  endtask

  task automatic step(input logic e, input logic [TW-1:0] t, input logic [DW-1:0] d,
                      input logic mn, input logic mx, input logic r);
    enq_in = e; enq_tag_in = t; enq_data_in = d;
    deq_min_in = mn; deq_max_in = mx; rst_in = r;
    model(e, t, d, mn, mx, r);
    @(posedge clk_in);
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic reset_q();  step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle();     step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); endtask
  task automatic enq(input logic [TW-1:0] t, input logic [DW-1:0] d);
    step(1'b1, t, d, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic deq(input logic mn, input logic mx); step(1'b0, '0, '0, mn, mx, 1'b0); endtask
  task automatic wait_scan(); for (int i = 0; i < DEPTH; i++) idle(); endtask

  initial begin
    int low;
    @(negedge clk_in);
    reset_q();
    check("rst_min", 64'(min_tag_out), 64'hFFFF_FFFF);

    enq(5, 32'hA); enq(2, 32'hB); enq(9, 32'hC); enq(2, 32'hD);
    check("tp1_size", 64'(size_out), 64'd4);
    deq(1'b1, 1'b0);
    check("tp1_tag", 64'(tag_out), 64'd2);
    check("tp1_data", 64'(data_out), 64'hB);
    low = 1;
    for (int i = 0; i < 12 && !deq_ready_out; i++) begin
      idle();
      if (!deq_ready_out) low++;
    end
    check("tp2_ready_low", 64'(low), 64'(DEPTH));
    deq(1'b0, 1'b1);
    check("tp2_max_data", 64'(data_out), 64'hC);
    wait_scan();
    deq(1'b1, 1'b0);
    check("tp2_min_data", 64'(data_out), 64'hD);

    reset_q();
    for (int i = 0; i < DEPTH; i++) enq(TW'(10 + i), DW'(100 + i));
    enq(1, 32'h55);
    check("tp3_full", 64'(full_out), 64'd1);
    step(1'b1, 3, 32'h33, 1'b1, 1'b0, 1'b0);
    check("tp3_size", 64'(size_out), 64'd7);
    wait_scan();
    check("tp3_min", 64'(min_tag_out), 64'd11);

    reset_q();
    enq(5, 1); enq(6, 2); enq(7, 3);
    deq(1'b1, 1'b0);
    idle(); idle();
    enq(1, 32'h77);
    wait_scan();
    check("tp4_min", 64'(min_tag_out), 64'd1);
    deq(1'b1, 1'b0);
    check("tp4_data", 64'(data_out), 64'h77);

    reset_q();
    enq(4, 4); enq(7, 7);
    deq(1'b1, 1'b1);
    check("tp5_tag", 64'(tag_out), 64'd4);
    wait_scan();
    reset_q();
    deq(1'b1, 1'b0);
    check("tp5_empty_vout", 64'(valid_out), 64'd0);

    enq(8, 1); enq(3, 2); enq(5, 3);
    deq(1'b0, 1'b1);
    idle(); idle();
    reset_q();
    check("tp6_max", 64'(max_tag_out), 64'd0);
    enq(6, 6);
    check("tp6_min", 64'(min_tag_out), 64'd6);

    for (int n = 0; n < 3000; n++) begin
      logic [TW-1:0] t;
      int k = $urandom_range(0, 19);
      t = (k == 0) ? '1 : (k == 1) ? '0 : TW'($urandom_range(0, 7));
      step($urandom_range(0, 2) != 0, t, DW'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
